// File: rtl/packet_det_pkg.sv
// Shared packet-detect definitions: datapath width defaults and the
// round/scale/saturate helper used by the multiplier and the accumulator.
package packet_det_pkg;

  localparam int DIN_W_DEF  = 16;
  localparam int DOUT_W_DEF = 16;
  localparam int SHIFT_DEF  = 15;

  // Clamped value (sign-extended to 64 bits) plus a flag that the clamp fired.
  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } sat_res_t;

  // Half-up round, arithmetic shift by `shift`, clamp to a signed dout_w range.
  // Carried at 64 bits, so callers need 2*DIN_W+2 <= 64 for the round add
  // to stay wrap-free.
  function automatic sat_res_t sat_round(input logic signed [63:0] x,
                                         input int shift,
                                         input int dout_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           res;
    r = x;
    if (shift > 0) r = x + (64'sd1 <<< (shift - 1));
    r  = r >>> shift;
    hi = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dout_w - 1));
    res.sat = 1'b1;
    if (r > hi)      res.val = hi;
    else if (r < lo) res.val = lo;
    else begin
      res.val = r;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/packet_det_cmul_pipe_if.sv
// Stream bus of the complex multiplier: input beat, output beat and
// saturation status. slave = multiplier side, master = driver side.
interface packet_det_cmul_pipe_if
  import packet_det_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF
) ();

  logic                     s_valid;
  logic                     s_ready;
  logic                     s_conj;
  logic signed [DIN_W-1:0]  s_a_re;
  logic signed [DIN_W-1:0]  s_a_im;
  logic signed [DIN_W-1:0]  s_b_re;
  logic signed [DIN_W-1:0]  s_b_im;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DOUT_W-1:0] m_re;
  logic signed [DOUT_W-1:0] m_im;
  logic                     m_sat;
  logic                     sat_sticky;
  logic                     sat_clr;

  modport slave (
    input  s_valid, s_conj, s_a_re, s_a_im, s_b_re, s_b_im, m_ready, sat_clr,
    output s_ready, m_valid, m_re, m_im, m_sat, sat_sticky
  );

  modport master (
    output s_valid, s_conj, s_a_re, s_a_im, s_b_re, s_b_im, m_ready, sat_clr,
    input  s_ready, m_valid, m_re, m_im, m_sat, sat_sticky
  );

endinterface

// File: rtl/packet_det_pipe_ctl.sv
// Valid/advance chain for a STAGES-deep pipeline with collapsing bubbles.
// A stage advances when it is empty or its successor advances; load[k]
// tells the datapath to capture new content into stage k.
module packet_det_pipe_ctl #(
  parameter int STAGES = 3
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic              in_ready,
  output logic              out_valid,
  output logic [STAGES:1]   load
);

  logic [STAGES:1]   vld_q;
  logic [STAGES:1]   vld_d;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES+1:1] adv;

  // Advance chain resolved from the output backwards; in_ready never sees in_valid.
  always_comb begin
    vld_pipe        = {vld_q, in_valid};
    adv             = '0;
    adv[STAGES+1]   = out_ready;
    load            = '0;
    vld_d           = vld_q;
    for (int k = STAGES; k >= 1; k--) begin
      adv[k]   = !vld_q[k] || adv[k+1];
      load[k]  = adv[k] && vld_pipe[k-1];
      vld_d[k] = adv[k] ? vld_pipe[k-1] : vld_q[k];
    end
    in_ready  = adv[1];
    out_valid = vld_q[STAGES];
  end

  // Stage valid register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) vld_q <= '0;
    else           vld_q <= vld_d;
  end

endmodule

// File: rtl/packet_det_cmul_pipe.sv
// Pipelined signed complex multiply (a*b or a*conj(b)) with round, scale and
// saturate. S1 captures operands, S2 the four partial products, S3 the final
// rounded/clamped result. Interface widths must match DIN_W/DOUT_W.
module packet_det_cmul_pipe
  import packet_det_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  packet_det_cmul_pipe_if.slave  bus
);

  localparam int PROD_W = 2 * DIN_W;
  localparam int SUM_W  = 2 * DIN_W + 1;

  logic       in_ready;
  logic       out_valid;
  logic [3:1] load;

  logic signed [DIN_W-1:0]  a_re_q, a_im_q, b_re_q, b_im_q;
  logic signed [DIN_W-1:0]  a_re_d, a_im_d, b_re_d, b_im_d;
  logic                     conj1_q, conj1_d, conj2_q, conj2_d;
  logic signed [PROD_W-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [PROD_W-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic signed [SUM_W-1:0]  re_sum, im_sum;
  sat_res_t                 re_r, im_r;
  logic signed [DOUT_W-1:0] m_re_q, m_im_q, m_re_d, m_im_d;
  logic                     m_sat_q, m_sat_d;
  logic                     sat_sticky_q, sat_sticky_d;
  logic                     unused_hi;

  packet_det_pipe_ctl #(.STAGES(3)) u_ctl (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (bus.s_valid),
    .out_ready (bus.m_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .load      (load)
  );

  // S1: capture operands and the conjugate select.
  always_comb begin
    a_re_d  = a_re_q;
    a_im_d  = a_im_q;
    b_re_d  = b_re_q;
    b_im_d  = b_im_q;
    conj1_d = conj1_q;
    if (load[1]) begin
      a_re_d  = bus.s_a_re;
      a_im_d  = bus.s_a_im;
      b_re_d  = bus.s_b_re;
      b_im_d  = bus.s_b_im;
      conj1_d = bus.s_conj;
    end
  end

  // S2: four full-width signed products (one DSP each).
  always_comb begin
    p_rr_d  = p_rr_q;
    p_ii_d  = p_ii_q;
    p_ri_d  = p_ri_q;
    p_ir_d  = p_ir_q;
    conj2_d = conj2_q;
    if (load[2]) begin
      p_rr_d  = PROD_W'(a_re_q) * PROD_W'(b_re_q);
      p_ii_d  = PROD_W'(a_im_q) * PROD_W'(b_im_q);
      p_ri_d  = PROD_W'(a_re_q) * PROD_W'(b_im_q);
      p_ir_d  = PROD_W'(a_im_q) * PROD_W'(b_re_q);
      conj2_d = conj1_q;
    end
  end

  // S3: combine products, round/shift/clamp, and track sticky saturation.
  always_comb begin
    re_sum = conj2_q ? (SUM_W'(p_rr_q) + SUM_W'(p_ii_q))
                     : (SUM_W'(p_rr_q) - SUM_W'(p_ii_q));
    im_sum = conj2_q ? (SUM_W'(p_ir_q) - SUM_W'(p_ri_q))
                     : (SUM_W'(p_ri_q) + SUM_W'(p_ir_q));
    re_r   = sat_round(64'(re_sum), SHIFT, DOUT_W);
    im_r   = sat_round(64'(im_sum), SHIFT, DOUT_W);
    m_re_d  = m_re_q;
    m_im_d  = m_im_q;
    m_sat_d = m_sat_q;
    if (load[3]) begin
      m_re_d  = re_r.val[DOUT_W-1:0];
      m_im_d  = im_r.val[DOUT_W-1:0];
      m_sat_d = re_r.sat | im_r.sat;
    end
    // A saturated beat leaving in the same cycle as a clear keeps the flag set.
    sat_sticky_d = bus.sat_clr ? 1'b0 : sat_sticky_q;
    if (out_valid && bus.m_ready && m_sat_q) sat_sticky_d = 1'b1;
  end

  // Clamped values already fit DOUT_W; the upper bits are only sign copies.
  assign unused_hi = ^{re_r.val[63:DOUT_W], im_r.val[63:DOUT_W]};

  // Datapath and status registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_re_q       <= '0;
      a_im_q       <= '0;
      b_re_q       <= '0;
      b_im_q       <= '0;
      conj1_q      <= 1'b0;
      p_rr_q       <= '0;
      p_ii_q       <= '0;
      p_ri_q       <= '0;
      p_ir_q       <= '0;
      conj2_q      <= 1'b0;
      m_re_q       <= '0;
      m_im_q       <= '0;
      m_sat_q      <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      a_re_q       <= a_re_d;
      a_im_q       <= a_im_d;
      b_re_q       <= b_re_d;
      b_im_q       <= b_im_d;
      conj1_q      <= conj1_d;
      p_rr_q       <= p_rr_d;
      p_ii_q       <= p_ii_d;
      p_ri_q       <= p_ri_d;
      p_ir_q       <= p_ir_d;
      conj2_q      <= conj2_d;
      m_re_q       <= m_re_d;
      m_im_q       <= m_im_d;
      m_sat_q      <= m_sat_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign bus.s_ready    = in_ready;
  assign bus.m_valid    = out_valid;
  assign bus.m_re       = m_re_q;
  assign bus.m_im       = m_im_q;
  assign bus.m_sat      = m_sat_q;
  assign bus.sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_packet_det_cmul_pipe.sv
// Scoreboard bench for packet_det_cmul_pipe: accepted beats push expected
// results (spec constants or an arithmetic reference), a monitor pops on
// every output handshake.
module tb_packet_det_cmul_pipe;

  localparam int DIN_W  = 16;
  localparam int DOUT_W = 16;
  localparam int SHIFT  = 15;

  typedef struct {
    longint re;
    longint im;
    bit     sat;
    int     acc_cyc;
    bit     chk_lat;
  } exp_t;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  packet_det_cmul_pipe_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) bus ();

  packet_det_cmul_pipe #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .SHIFT(SHIFT)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  exp_t sb[$];
  exp_t dir_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   occ = 0;
  bit   lat_mode = 1'b0;
  bit   rand_rdy = 1'b0;
  bit   hold_prev = 1'b0;
  logic signed [DOUT_W-1:0] prev_re, prev_im;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact complex product, then floor((x + half) / 2^SHIFT), then clamp.
  function automatic longint ref_scale(input longint x, output bit s);
    longint r, hi, lo;
    r  = x;
    if (SHIFT > 0) r = x + (longint'(1) << (SHIFT - 1));
    r  = r >>> SHIFT;
    hi = (longint'(1) << (DOUT_W - 1)) - 1;
    lo = -(longint'(1) << (DOUT_W - 1));
    s  = 1'b0;
    if (r > hi) begin r = hi; s = 1'b1; end
    else if (r < lo) begin r = lo; s = 1'b1; end
    return r;
  endfunction

  function automatic exp_t ref_model(input bit c, input longint ar, input longint ai,
                                     input longint br, input longint bi);
    exp_t   e;
    bit     sr, si;
    longint re_raw, im_raw;
    re_raw = c ? (ar * br + ai * bi) : (ar * br - ai * bi);
    im_raw = c ? (ai * br - ar * bi) : (ar * bi + ai * br);
    e.re   = ref_scale(re_raw, sr);
    e.im   = ref_scale(im_raw, si);
    e.sat  = sr | si;
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  function automatic int rv();
    logic signed [DIN_W-1:0] t;
    case ($urandom_range(0, 5))
      0:       t = -16'sd32768;
      1:       t = 16'sd32767;
      default: t = DIN_W'($urandom);
    endcase
    return int'(t);
  endfunction

  always @(posedge ap_clk) cyc++;

  // Random downstream backpressure.
  always @(posedge ap_clk) begin
    if (rand_rdy) begin
      #1;
      bus.m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Acceptor: every input handshake pushes its expected result.
  always @(negedge ap_clk) begin
    if (ap_rst_n && bus.s_valid && bus.s_ready) begin
      exp_t e;
      if (dir_q.size() > 0) e = dir_q.pop_front();
      else e = ref_model(bus.s_conj, longint'(bus.s_a_re), longint'(bus.s_a_im),
                         longint'(bus.s_b_re), longint'(bus.s_b_im));
      e.acc_cyc = cyc;
      e.chk_lat = lat_mode;
      sb.push_back(e);
    end
  end

  // Monitor: output handshakes, hold stability and the s_ready rule.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      occ       = 0;
      hold_prev = 1'b0;
    end else begin
      check("s_ready_rule", bus.s_ready, !(occ == 3 && !bus.m_ready));
      if (hold_prev) begin
        check("hold_valid", bus.m_valid, 1);
        check("hold_re", longint'(bus.m_re), longint'(prev_re));
        check("hold_im", longint'(bus.m_im), longint'(prev_im));
      end
      hold_prev = bus.m_valid && !bus.m_ready;
      prev_re   = bus.m_re;
      prev_im   = bus.m_im;
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: re=%0d im=%0d with empty scoreboard", bus.m_re, bus.m_im);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("m_re", longint'(bus.m_re), e.re);
          check("m_im", longint'(bus.m_im), e.im);
          check("m_sat", bus.m_sat, e.sat);
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, 3);
        end
        occ--;
      end
      if (bus.s_valid && bus.s_ready) occ++;
    end
  end

  task automatic send(input bit c, input int ar, input int ai, input int br, input int bi);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_conj  = c;
    bus.s_a_re  = DIN_W'(ar);
    bus.s_a_im  = DIN_W'(ai);
    bus.s_b_re  = DIN_W'(br);
    bus.s_b_im  = DIN_W'(bi);
    for (int i = 0; i < 200; i++) begin
      @(negedge ap_clk);
      if (bus.s_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge ap_clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_exp(input bit c, input int ar, input int ai, input int br, input int bi,
                          input longint re, input longint im, input bit sat);
    exp_t e;
    e.re = re; e.im = im; e.sat = sat; e.acc_cyc = 0; e.chk_lat = 1'b0;
    dir_q.push_back(e);
    send(c, ar, ai, br, bi);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge ap_clk); #1;
      if (sb.size() == 0 && occ == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0; bus.s_conj = 1'b0;
    bus.s_a_re = '0; bus.s_a_im = '0; bus.s_b_re = '0; bus.s_b_im = '0;
    bus.m_ready = 1'b1; bus.sat_clr = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_re", longint'(bus.m_re), 0);
    check("rst_m_im", longint'(bus.m_im), 0);
    check("rst_m_sat", bus.m_sat, 0);
    check("rst_sat_sticky", bus.sat_sticky, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("post_rst_s_ready", bus.s_ready, 1);
    @(posedge ap_clk); #1;

    // Directed vectors at full throughput; latency checked on each.
    lat_mode = 1'b1;
    send_exp(0, 16384, 0, 16384, 0, 8192, 0, 0);
    drain();
    send_exp(0, 0, 16384, 0, 16384, -8192, 0, 0);
    send_exp(1, 0, 16384, 0, 16384, 8192, 0, 0);
    send_exp(0, 1, 0, 16384, 0, 1, 0, 0);
    send_exp(0, -1, 0, 16384, 0, 0, 0, 0);
    send_exp(0, 1, 0, 16383, 0, 0, 0, 0);
    send_exp(0, -32768, -32768, -32768, -32768, 0, 32767, 1);
    drain();
    check("sticky_set", bus.sat_sticky, 1);
    bus.sat_clr = 1'b1;
    @(posedge ap_clk); #1;
    bus.sat_clr = 1'b0;
    check("sticky_clr", bus.sat_sticky, 0);

    // Clear coinciding with a saturated accept: the set wins.
    lat_mode = 1'b0;
    bus.m_ready = 1'b0;
    send_exp(0, -32768, -32768, -32768, -32768, 0, 32767, 1);
    for (int i = 0; i < 20; i++) begin
      if (bus.m_valid) break;
      @(posedge ap_clk); #1;
    end
    check("sat_beat_waiting", bus.m_valid, 1);
    check("sticky_before_accept", bus.sat_sticky, 0);
    bus.sat_clr = 1'b1;
    bus.m_ready = 1'b1;
    @(posedge ap_clk); #1;
    bus.sat_clr = 1'b0;
    check("sticky_set_wins", bus.sat_sticky, 1);
    drain();
    bus.sat_clr = 1'b1;
    @(posedge ap_clk); #1;
    bus.sat_clr = 1'b0;
    check("sticky_clr2", bus.sat_sticky, 0);

    // 20 random beats under ~50% backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)), rv(), rv(), rv(), rv());
    rand_rdy = 1'b0;
    @(posedge ap_clk); #2;
    bus.m_ready = 1'b1;
    drain();

    // 30 random beats back-to-back, no stall.
    lat_mode = 1'b1;
    for (int i = 0; i < 30; i++) send(1'($urandom_range(0, 1)), rv(), rv(), rv(), rv());
    drain();

    // Reset with three beats in flight (sticky set beforehand so the clear is visible).
    send_exp(0, -32768, -32768, -32768, -32768, 0, 32767, 1);
    drain();
    check("sticky_pre_reset", bus.sat_sticky, 1);
    lat_mode = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'($urandom_range(0, 1)), rv(), rv(), rv(), rv());
    check("inflight_m_valid", bus.m_valid, 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", bus.m_valid, 0);
    check("async_rst_sticky", bus.sat_sticky, 0);
    sb.delete();
    dir_q.delete();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      check("no_output_after_rst", bus.m_valid, 0);
    end
    @(posedge ap_clk); #1;
    lat_mode = 1'b1;
    send_exp(1, 0, 16384, 0, 16384, 8192, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
